// File: rtl/trdb_priority_bm.sv
// trdb_priority_bm: per-instruction packet priority, branch map and resync tracking behind a valid/ready output register.
// Optional support packets (F3 SF3) on encoder control events when TRDB_SUPPORT_PKT_EN is defined.
module trdb_priority_bm #(
    parameter int BMAP_DEPTH = 31,
    parameter int RESYNC_W = 16,
    parameter int CNT_W = $clog2(BMAP_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  lc_exception_i,
    input  logic                  lc_updiscon_i,
    input  logic                  tc_qualified_i,
    input  logic                  tc_exception_i,
    input  logic                  tc_retired_i,
    input  logic                  tc_first_qualified_i,
    input  logic                  tc_privchange_i,
    input  logic                  tc_branch_i,
    input  logic                  tc_branch_taken_i,
    input  logic                  tc_enc_enabled_i,
    input  logic                  tc_enc_disabled_i,
    input  logic                  tc_opmode_change_i,
    input  logic                  nc_exception_i,
    input  logic                  nc_privchange_i,
    input  logic                  nc_context_change_i,
    input  logic                  nc_qualified_i,
    input  logic [RESYNC_W-1:0]   resync_max_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [1:0]            packet_format_o,
    output logic [1:0]            packet_f_sync_subformat_o,
    output logic                  thaddr_o,
    output logic                  cause_mux_o,
    output logic                  tval_mux_o,
    output logic                  resync_rst_o,
    output logic [CNT_W-1:0]      branch_cnt_o,
    output logic [BMAP_DEPTH-1:0] branch_map_o
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BMAP_DEPTH);
    logic [CNT_W-1:0] cnt_q, cnt_a;
    logic [BMAP_DEPTH-1:0] map_q, map_a;
    logic [RESYNC_W-1:0] rc_q, rc_inc;
    logic pend_q, pend_now, accept, brn, zero, pkt, clr, sup, sup_clr;
    logic thaddr, mux, rrst;
    logic [1:0] fmt, sf, f12;

`ifdef TRDB_SUPPORT_PKT_EN
    assign sup = tc_enc_enabled_i || tc_enc_disabled_i || tc_opmode_change_i;
    assign sup_clr = tc_enc_disabled_i;
`else
    logic unused_ctrl;
    assign unused_ctrl = ^{tc_enc_enabled_i, tc_enc_disabled_i, tc_opmode_change_i};
    assign sup = 1'b0;
    assign sup_clr = 1'b0;
`endif

    assign ready_o = !valid_o || ready_i;
    assign accept = valid_i && ready_o;

    always_comb begin
        brn = tc_qualified_i && tc_branch_i && (cnt_q < FULL);
        cnt_a = cnt_q + CNT_W'(brn);
        map_a = map_q | (BMAP_DEPTH'(brn && tc_branch_taken_i) << cnt_q);
        rc_inc = rc_q + RESYNC_W'(rc_q != '1);
        // resync becomes pending on the very slot that reaches the threshold
        pend_now = pend_q || ((resync_max_i != '0) && (rc_inc >= resync_max_i));
        zero = cnt_a == '0;
        f12 = zero ? 2'd2 : 2'd1;
        pkt = 1'b0;
        fmt = 2'd0;
        sf = 2'd0;
        thaddr = 1'b0;
        mux = 1'b0;
        rrst = 1'b0;
        if (sup) begin
            pkt = 1'b1;
            fmt = 2'd3;
            sf = 2'd3;
        end else if (!tc_qualified_i) begin
            pkt = 1'b0;
        end else if (lc_exception_i) begin
            {pkt, fmt, sf, thaddr, rrst} = {1'b1, 2'd3, 2'd1, 1'b1, 1'b1};
        end else if (tc_exception_i && !tc_retired_i) begin
            {pkt, fmt, sf, mux, rrst} = {1'b1, 2'd3, 2'd1, 1'b1, 1'b1};
        end else if (tc_first_qualified_i || tc_privchange_i || (pend_now && zero)) begin
            {pkt, fmt, rrst} = {1'b1, 2'd3, 1'b1};
        end else if (lc_updiscon_i) begin
            {pkt, fmt} = {1'b1, f12};
        end else if (pend_now) begin
            {pkt, fmt} = {1'b1, 2'd1};
        end else if (nc_exception_i || nc_privchange_i || nc_context_change_i || !nc_qualified_i) begin
            {pkt, fmt} = {1'b1, f12};
        end else if (cnt_a == FULL) begin
            {pkt, fmt} = {1'b1, 2'd1};
        end
        clr = pkt && (!sup || sup_clr);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            map_q <= '0;
            rc_q <= '0;
            pend_q <= 1'b0;
            valid_o <= 1'b0;
            packet_format_o <= '0;
            packet_f_sync_subformat_o <= '0;
            thaddr_o <= 1'b0;
            cause_mux_o <= 1'b0;
            tval_mux_o <= 1'b0;
            resync_rst_o <= 1'b0;
            branch_cnt_o <= '0;
            branch_map_o <= '0;
        end else begin
            if (accept) begin
                cnt_q <= clr ? '0 : cnt_a;
                map_q <= clr ? '0 : map_a;
                if (rrst) begin
                    rc_q <= '0;
                    pend_q <= 1'b0;
                end else if (tc_qualified_i && !sup) begin
                    rc_q <= rc_inc;
                    pend_q <= pend_now;
                end
            end
            if (ready_o) begin
                valid_o <= accept && pkt;
                if (accept && pkt) begin
                    packet_format_o <= fmt;
                    packet_f_sync_subformat_o <= sf;
                    thaddr_o <= thaddr;
                    cause_mux_o <= mux;
                    tval_mux_o <= mux;
                    resync_rst_o <= rrst;
                    branch_cnt_o <= cnt_a;
                    branch_map_o <= map_a;
                end
            end
        end
    end
endmodule

// File: tb/tb_trdb_priority_bm.sv
// tb_trdb_priority_bm: directed-vector bench for trdb_priority_bm with the default BMAP_DEPTH=31.
module tb_trdb_priority_bm;
    logic clk_i = 1'b0, rst_i, valid_i, ready_o;
    logic lc_exception_i, lc_updiscon_i;
    logic tc_qualified_i, tc_exception_i, tc_retired_i, tc_first_qualified_i, tc_privchange_i;
    logic tc_branch_i, tc_branch_taken_i, tc_enc_enabled_i, tc_enc_disabled_i, tc_opmode_change_i;
    logic nc_exception_i, nc_privchange_i, nc_context_change_i, nc_qualified_i;
    logic [15:0] resync_max_i = '0;
    logic valid_o, ready_i;
    logic [1:0] packet_format_o, packet_f_sync_subformat_o;
    logic thaddr_o, cause_mux_o, tval_mux_o, resync_rst_o;
    logic [4:0] branch_cnt_o;
    logic [30:0] branch_map_o;
    logic [8:0] ctl;
    int vec = 0, miss = 0;

    trdb_priority_bm dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .lc_exception_i(lc_exception_i), .lc_updiscon_i(lc_updiscon_i),
        .tc_qualified_i(tc_qualified_i), .tc_exception_i(tc_exception_i),
        .tc_retired_i(tc_retired_i), .tc_first_qualified_i(tc_first_qualified_i),
        .tc_privchange_i(tc_privchange_i), .tc_branch_i(tc_branch_i),
        .tc_branch_taken_i(tc_branch_taken_i), .tc_enc_enabled_i(tc_enc_enabled_i),
        .tc_enc_disabled_i(tc_enc_disabled_i), .tc_opmode_change_i(tc_opmode_change_i),
        .nc_exception_i(nc_exception_i), .nc_privchange_i(nc_privchange_i),
        .nc_context_change_i(nc_context_change_i), .nc_qualified_i(nc_qualified_i),
        .resync_max_i(resync_max_i), .valid_o(valid_o), .ready_i(ready_i),
        .packet_format_o(packet_format_o), .packet_f_sync_subformat_o(packet_f_sync_subformat_o),
        .thaddr_o(thaddr_o), .cause_mux_o(cause_mux_o), .tval_mux_o(tval_mux_o),
        .resync_rst_o(resync_rst_o), .branch_cnt_o(branch_cnt_o), .branch_map_o(branch_map_o)
    );

    always #5 clk_i = ~clk_i;
    // {valid, format, subformat, thaddr, cause_mux, tval_mux, resync_rst}
    assign ctl = {valid_o, packet_format_o, packet_f_sync_subformat_o, thaddr_o, cause_mux_o, tval_mux_o, resync_rst_o};

    task automatic idle();
        {valid_i, lc_exception_i, lc_updiscon_i, tc_qualified_i, tc_exception_i, tc_retired_i} = '0;
        {tc_first_qualified_i, tc_privchange_i, tc_branch_i, tc_branch_taken_i} = '0;
        {tc_enc_enabled_i, tc_enc_disabled_i, tc_opmode_change_i} = '0;
        {nc_exception_i, nc_privchange_i, nc_context_change_i} = '0;
        nc_qualified_i = 1'b1;
        ready_i = 1'b1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic qslot();
        idle();
        valid_i = 1'b1;
        tc_qualified_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (ctl !== 9'b0) begin miss++; $display("FAIL reset_ctl got %b exp %b", ctl, 9'b0); end
        vec++; if (ready_o !== 1'b1) begin miss++; $display("FAIL reset_ready got %b exp 1", ready_o); end
        vec++; if ({branch_cnt_o, branch_map_o} !== 36'h0) begin miss++; $display("FAIL reset_bm got %h exp 0", {branch_cnt_o, branch_map_o}); end
    endtask

    task automatic test_first();
        do_reset();
        qslot();
        tc_first_qualified_i = 1'b1;
        step();
        vec++; if (ctl !== 9'b1_11_00_0001) begin miss++; $display("FAIL first_ctl got %b exp %b", ctl, 9'b1_11_00_0001); end
        vec++; if (branch_cnt_o !== 5'd0) begin miss++; $display("FAIL first_cnt got %0d exp 0", branch_cnt_o); end
        idle();
        step();
        vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL first_drain got %b exp 0", valid_o); end
    endtask

    task automatic test_full_map();
        do_reset();
        for (int i = 0; i < 31; i++) begin
            qslot();
            tc_branch_i = 1'b1;
            tc_branch_taken_i = 1'b1;
            step();
            if (i < 30) begin
                vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL map_early[%0d] got %b exp 0", i, valid_o); end
            end
        end
        vec++; if (ctl !== 9'b1_01_00_0000) begin miss++; $display("FAIL map_full_ctl got %b exp %b", ctl, 9'b1_01_00_0000); end
        vec++; if (branch_cnt_o !== 5'd31) begin miss++; $display("FAIL map_full_cnt got %0d exp 31", branch_cnt_o); end
        vec++; if (branch_map_o !== 31'h7fff_ffff) begin miss++; $display("FAIL map_full_map got %h exp 7fffffff", branch_map_o); end
        qslot();
        tc_branch_i = 1'b1;
        tc_branch_taken_i = 1'b1;
        lc_updiscon_i = 1'b1;
        step();
        vec++; if ({ctl, branch_cnt_o, branch_map_o} !== {9'b1_01_00_0000, 5'd1, 31'h1}) begin
            miss++; $display("FAIL map_restart got %b/%0d/%h exp F1/1/1", ctl, branch_cnt_o, branch_map_o);
        end
    endtask

    task automatic test_resync();
        do_reset();
        resync_max_i = 16'd4;
        for (int i = 0; i < 3; i++) begin
            qslot();
            tc_branch_i = (i < 2);
            tc_branch_taken_i = (i == 0);
            step();
            vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL resync_early[%0d] got %b exp 0", i, valid_o); end
        end
        qslot();
        step();
        vec++; if ({ctl, branch_cnt_o, branch_map_o} !== {9'b1_01_00_0000, 5'd2, 31'h1}) begin
            miss++; $display("FAIL resync_f1 got %b/%0d/%h exp F1/2/1", ctl, branch_cnt_o, branch_map_o);
        end
        qslot();
        step();
        vec++; if (ctl !== 9'b1_11_00_0001) begin miss++; $display("FAIL resync_sync got %b exp %b", ctl, 9'b1_11_00_0001); end
        qslot();
        step();
        vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL resync_cleared got %b exp 0", valid_o); end
        resync_max_i = '0;
    endtask

    task automatic test_exception();
        do_reset();
        resync_max_i = 16'd1;
        qslot();
        lc_exception_i = 1'b1;
        step();
        vec++; if (ctl !== 9'b1_11_01_1001) begin miss++; $display("FAIL exc_lc got %b exp %b", ctl, 9'b1_11_01_1001); end
        qslot();
        tc_exception_i = 1'b1;
        step();
        vec++; if (ctl !== 9'b1_11_01_0111) begin miss++; $display("FAIL exc_tc got %b exp %b", ctl, 9'b1_11_01_0111); end
        resync_max_i = '0;
        qslot();
        tc_exception_i = 1'b1;
        tc_retired_i = 1'b1;
        step();
        vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL exc_retired got %b exp 0", valid_o); end
    endtask

    task automatic test_discon();
        do_reset();
        idle();
        valid_i = 1'b1;
        tc_branch_i = 1'b1;
        tc_branch_taken_i = 1'b1;
        step();
        vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL unqual_slot got %b exp 0", valid_o); end
        qslot();
        lc_updiscon_i = 1'b1;
        step();
        vec++; if ({ctl, branch_cnt_o} !== {9'b1_10_00_0000, 5'd0}) begin miss++; $display("FAIL discon_f2 got %b/%0d exp F2/0", ctl, branch_cnt_o); end
        qslot();
        tc_branch_i = 1'b1;
        nc_qualified_i = 1'b0;
        step();
        vec++; if ({ctl, branch_cnt_o, branch_map_o} !== {9'b1_01_00_0000, 5'd1, 31'h0}) begin
            miss++; $display("FAIL nc_f1 got %b/%0d/%h exp F1/1/0", ctl, branch_cnt_o, branch_map_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        qslot();
        lc_updiscon_i = 1'b1;
        ready_i = 1'b0;
        step();
        tc_branch_i = 1'b1;
        tc_branch_taken_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec++; if ({ready_o, ctl, branch_cnt_o} !== {1'b0, 9'b1_10_00_0000, 5'd0}) begin
                miss++; $display("FAIL stall[%0d] got %b/%b/%0d exp 0/F2/0", i, ready_o, ctl, branch_cnt_o);
            end
            step();
        end
        ready_i = 1'b1;
        #1;
        vec++; if (ready_o !== 1'b1) begin miss++; $display("FAIL stall_release got %b exp 1", ready_o); end
        step();
        vec++; if ({ctl, branch_cnt_o, branch_map_o} !== {9'b1_01_00_0000, 5'd1, 31'h1}) begin
            miss++; $display("FAIL stall_next got %b/%0d/%h exp F1/1/1", ctl, branch_cnt_o, branch_map_o);
        end
        qslot();
        lc_updiscon_i = 1'b1;
        ready_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL stall_reset got %b exp 0", valid_o); end
    endtask

    task automatic test_support();
        do_reset();
        idle();
        valid_i = 1'b1;
        tc_opmode_change_i = 1'b1;
        step();
`ifdef TRDB_SUPPORT_PKT_EN
        vec++; if (ctl !== 9'b1_11_11_0000) begin miss++; $display("FAIL support_pkt got %b exp %b", ctl, 9'b1_11_11_0000); end
`else
        vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL support_off got %b exp 0", valid_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_first();
        test_full_map();
        test_resync();
        test_exception();
        test_discon();
        test_stall();
        test_support();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
